// File: rtl/prio_index_decoder.sv
// prio_index_decoder: rebuilds a request vector from a stream of priority-encoder
// indices. Each accepted beat ORs onehot(idx) into a frame mask. The beat tagged
// last publishes the finished vector, beat count and duplicate flag under a
// valid/ready handshake.
// Optional feature: define PRIO_DEC_DUP_DETECT_EN to build duplicate-index
// detection. When it is undefined, vec_dup is tied to 0.
module prio_index_decoder #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N),
    parameter int CNT_W = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] idx,
    input  logic             idx_valid,
    input  logic             idx_last,
    output logic             idx_ready,
    output logic [N-1:0]     vec,
    output logic [CNT_W-1:0] vec_cnt,
    output logic             vec_dup,
    output logic             vec_valid,
    input  logic             vec_ready
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state;
    logic [N-1:0]     mask;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     onehot;
    logic [CNT_W-1:0] cnt_inc;
    logic             beat;

    // Decode idx to a one-hot; an idx at or above N leaves every bit clear
    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            onehot[i] = (idx == IDX_W'(i));
        end
    end

    // Beat counter increment that saturates instead of wrapping
    always_comb begin
        cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    end

    assign idx_ready = rst_n & (state == ACCUM);
    assign beat      = idx_valid & idx_ready;

    // Frame accumulation and result handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACCUM;
            mask      <= '0;
            cnt       <= '0;
            vec       <= '0;
            vec_cnt   <= '0;
            vec_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (beat) begin
                        if (idx_last) begin
                            vec       <= mask | onehot;
                            vec_cnt   <= cnt_inc;
                            vec_valid <= 1'b1;
                            mask      <= '0;
                            cnt       <= '0;
                            state     <= HOLD;
                        end else begin
                            mask <= mask | onehot;
                            cnt  <= cnt_inc;
                        end
                    end
                end
                HOLD: begin
                    if (vec_valid && vec_ready) begin
                        vec_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

`ifdef PRIO_DEC_DUP_DETECT_EN
    logic dup;
    logic dup_hit;

    assign dup_hit = |(mask & onehot);

    // Track repeated in-range indices within a frame; publish with the vector
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dup     <= 1'b0;
            vec_dup <= 1'b0;
        end else if (beat) begin
            if (idx_last) begin
                vec_dup <= dup | dup_hit;
                dup     <= 1'b0;
            end else begin
                dup <= dup | dup_hit;
            end
        end
    end
`else
    assign vec_dup = 1'b0;
`endif

endmodule
